// File: rtl/ascii_row_to_sensor_data.sv
// Parser for "SENS: <digits><term>" ASCII lines. Scales the decimal value by SCALE,
// saturates it to 16 bits and presents it over a valid/ready handshake.
module ascii_row_to_sensor_data #(
  parameter int unsigned MAX_DIGITS = 5,
  parameter int unsigned SCALE      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_char,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] sensor_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sat,
  output logic        err
);

  localparam int unsigned CntW  = $clog2(MAX_DIGITS + 1);
  localparam int unsigned ProdW = 17 + $clog2(SCALE + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_DIGITS);

  typedef enum logic [1:0] {StPrefix, StDigits, StSkip, StHold} state_e;

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [16:0]       acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [15:0]       data_q, data_d;
  logic              sat_q, sat_d;
  logic              err_q, err_d;

  logic              accept;
  logic              is_digit, is_eol, is_space;
  logic [7:0]        exp_char;
  logic [ProdW-1:0]  product;

  assign in_ready    = (state_q != StHold);
  assign out_valid   = (state_q == StHold);
  assign sensor_data = data_q;
  assign sat         = sat_q;
  assign err         = err_q;

  assign accept   = in_valid && in_ready;
  assign is_digit = (in_char >= 8'h30) && (in_char <= 8'h39);
  assign is_eol   = (in_char == 8'h0D) || (in_char == 8'h0A);
  assign is_space = (in_char == 8'h20);
  // Full-width product so the saturation test sees every overflowing bit.
  assign product  = ProdW'(acc_q) * ProdW'(SCALE);

  // Character of "SENS: " expected at the current prefix position.
  always_comb begin
    case (idx_q)
      3'd0:    exp_char = 8'h53;
      3'd1:    exp_char = 8'h45;
      3'd2:    exp_char = 8'h4E;
      3'd3:    exp_char = 8'h53;
      3'd4:    exp_char = 8'h3A;
      default: exp_char = 8'h20;
    endcase
  end

  // Next-state logic: prefix match, digit accumulation, discard, result hold.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sat_d   = sat_q;
    err_d   = 1'b0;
    unique case (state_q)
      StPrefix: begin
        if (accept) begin
          if (in_char == exp_char) begin
            if (idx_q == 3'd5) begin
              state_d = StDigits;
              acc_d   = '0;
              cnt_d   = '0;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            // A stray 'S' can itself start a new prefix.
            idx_d = (in_char == 8'h53) ? 3'd1 : 3'd0;
          end
        end
      end
      StDigits: begin
        if (accept) begin
          if (is_digit) begin
            if (cnt_q < MaxCnt) begin
              acc_d = acc_q * 17'd10 + 17'(in_char[3:0]);
              cnt_d = cnt_q + 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = StSkip;
            end
          end else if (is_space && (cnt_q == '0)) begin
            // Leading spaces before the number are tolerated.
          end else if (is_eol || is_space) begin
            if (cnt_q != '0) begin
              state_d = StHold;
              if (product > ProdW'(16'hFFFF)) begin
                data_d = 16'hFFFF;
                sat_d  = 1'b1;
              end else begin
                data_d = product[15:0];
                sat_d  = 1'b0;
              end
            end else begin
              err_d   = 1'b1;
              state_d = StPrefix;
              idx_d   = 3'd0;
            end
          end else begin
            err_d   = 1'b1;
            state_d = StSkip;
          end
        end
      end
      StSkip: begin
        if (accept && is_eol) begin
          state_d = StPrefix;
          idx_d   = 3'd0;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StPrefix;
          idx_d   = 3'd0;
        end
      end
      default: begin
        state_d = StPrefix;
        idx_d   = 3'd0;
      end
    endcase
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StPrefix;
      idx_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

endmodule
